concat_unpacker: RTL
====================

CONCAT_UNPACKER -- requirements
Module: concat_unpacker

Interface
REQ-001 Parameter CNT_W, default 8: width of the accepted-word counter.
REQ-002 clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 rst, input, 1: asynchronous, active-high reset.
REQ-004 in_word, input, 5: packed word, bit [4] = field A (1 bit), [3:2] = field B, [1:0] = field C.
REQ-005 in_valid, input, 1: in_word valid.
REQ-006 in_ready, output, 1: unpacker can accept a word this cycle.
REQ-007 field_data, output, 2: current field value; field A is zero-extended to {1'b0, A}.
REQ-008 field_id, output, 2: current field identity, 0 = A, 1 = B, 2 = C; value 3 is never driven.
REQ-009 field_last, output, 1: high while the field C beat is presented.
REQ-010 out_valid, output, 1: field_data, field_id and field_last are valid.
REQ-011 out_ready, input, 1: downstream accepts the current field.
REQ-012 word_count, output, CNT_W: number of words fully emitted (field C accepted).

Function
REQ-013 The FSM SHALL have states IDLE, EMIT_A, EMIT_B and EMIT_C.
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both high; in_word is captured into an internal 5-bit register on that edge.
REQ-015 An output transfer SHALL occur on a rising edge where out_valid and out_ready are both high.
REQ-016 IDLE: out_valid = 0 and in_ready = 1; an input transfer moves the FSM to EMIT_A.
REQ-017 EMIT_A: out_valid = 1, field_id = 0, field_data = {0, A}; an output transfer moves the FSM to EMIT_B, otherwise the FSM holds.
REQ-018 EMIT_B: out_valid = 1, field_id = 1, field_data = B; an output transfer moves the FSM to EMIT_C, otherwise the FSM holds.
REQ-019 EMIT_C: out_valid = 1, field_id = 2, field_data = C, field_last = 1; field_last is 0 in every other state.
REQ-020 EMIT_C exit: an output transfer increments word_count; if an input transfer occurs on the same edge, the FSM goes to EMIT_A with the new word, otherwise it goes to IDLE.
REQ-021 in_ready SHALL be (state == IDLE) or (state == EMIT_C and out_ready); this combinational path from out_ready to in_ready is intentional.
REQ-022 The first field SHALL be presented on the cycle after acceptance (latency 1 cycle).
REQ-023 Back-to-back words with out_ready held high SHALL give a throughput of one word per 3 cycles with no bubble between words.
REQ-024 While out_valid = 1 and out_ready = 0, field_data, field_id and field_last SHALL stay stable, and changes on in_word SHALL be ignored.
REQ-025 in_valid is ignored in EMIT_A and EMIT_B, and in EMIT_C while out_ready = 0.
REQ-026 word_count SHALL wrap from 2^CNT_W - 1 to 0 with no flag.
REQ-027 All outputs SHALL be registered-state decodes; the only combinational input-to-output path is in_ready.

Reset
REQ-028 While rst = 1: state = IDLE, capture register = 0, out_valid = 0, field_data = 0, field_id = 0, field_last = 0, word_count = 0, in_ready = 0.
REQ-029 in_ready SHALL go high on the first cycle after rst deasserts.
REQ-030 Reset asserted mid-word SHALL abandon the remaining fields immediately and SHALL leave word_count at 0.

Verification
REQ-031 Single word: in_word = 5'b0_01_10, out_ready = 1 -> beats (id, data) = (0, 00), (1, 01), (2, 10) on consecutive cycles, field_last on the third beat only, word_count = 1.
REQ-032 Back-pressure: in_word = 5'b1_11_01, out_ready low for 3 cycles during EMIT_B -> data 11 with id 1 held stable; in_ready = 0; C = 01 emitted after out_ready rises.
REQ-033 Back-to-back: words 5'b1_10_11 then 5'b0_00_00 with in_valid and out_ready high -> 6 beats in 6 cycles, with the second word accepted on the field C edge of the first; word_count = 2.
REQ-034 Reset mid-word: assert rst during EMIT_B -> out_valid = 0 and in_ready = 0 immediately, word_count = 0; after release a new word 5'b0_01_10 emits correctly.
REQ-035 Counter wrap: with CNT_W = 2, emit 5 words -> word_count sequence 1, 2, 3, 0, 1.
REQ-036 Ignored input: change in_word during EMIT_A -> the captured B and C values are emitted unchanged.

Source files
------------

// File: rtl/concat_unpacker.sv
// concat_unpacker
// Splits a packed 5-bit word {A[4], B[3:2], C[1:0]} into three beats on a
// valid/ready stream: A (zero-extended), B, then C. Beat C is tagged with
// field_last. A new word can be accepted on the same edge that the C beat is
// taken, so back-to-back words stream at one word per three cycles.
//
// State table
//   state  | meaning
//   IDLE   | no word held, ready for a new word
//   EMIT_A | presenting field A of the captured word
//   EMIT_B | presenting field B of the captured word
//   EMIT_C | presenting field C, may accept the next word
//
// Ports
//   clk, rst           clock, async active-high reset
//   in_word/in_valid   packed input word and its valid
//   in_ready           word accepted on this edge (combinational on out_ready)
//   field_data/id/last current beat payload, identity, end-of-word marker
//   out_valid/ready    output handshake
//   word_count         words fully emitted, wraps silently
module concat_unpacker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       field_data,
  output logic [1:0]       field_id,
  output logic             field_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EMIT_A = 2'd1;
  localparam logic [1:0] EMIT_B = 2'd2;
  localparam logic [1:0] EMIT_C = 2'd3;

  logic [1:0] state;
  logic [4:0] word_q;
  logic       in_xfer;
  logic       out_xfer;

  // rst gates in_ready so nothing is offered as accepted while held in reset.
  assign in_ready = ~rst & ((state == IDLE) | ((state == EMIT_C) & out_ready));
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_q     <= '0;
      word_count <= '0;
    end else begin
      if (in_xfer) begin
        word_q <= in_word;
      end
      case (state)
        IDLE: begin
          if (in_xfer) state <= EMIT_A;
        end
        EMIT_A: begin
          if (out_xfer) state <= EMIT_B;
        end
        EMIT_B: begin
          if (out_xfer) state <= EMIT_C;
        end
        EMIT_C: begin
          if (out_xfer) begin
            word_count <= word_count + 1'b1;
            state      <= in_xfer ? EMIT_A : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid  = 1'b0;
    field_id   = 2'd0;
    field_data = 2'd0;
    field_last = 1'b0;
    case (state)
      EMIT_A: begin
        out_valid  = 1'b1;
        field_id   = 2'd0;
        field_data = {1'b0, word_q[4]};
      end
      EMIT_B: begin
        out_valid  = 1'b1;
        field_id   = 2'd1;
        field_data = word_q[3:2];
      end
      EMIT_C: begin
        out_valid  = 1'b1;
        field_id   = 2'd2;
        field_data = word_q[1:0];
        field_last = 1'b1;
      end
      default: begin
        out_valid  = 1'b0;
      end
    endcase
  end

endmodule
